// File: rtl/bcd_adder_serial_if.sv
// Start/done handshake and operand/result bundle for the serial packed-BCD adder.
interface bcd_adder_serial_if #(parameter int DIGITS = 4);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  sub;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  busy;
    logic                  done;
    logic                  invalid;

    modport master (output start, a, b, cin, sub,
                    input  sum, cout, busy, done, invalid);
    modport slave  (input  start, a, b, cin, sub,
                    output sum, cout, busy, done, invalid);
endinterface

// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional subtract mode is enabled by defining BCD_SUB_EN.
module bcd_adder_serial #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_adder_serial_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [IW-1:0]  idx_r;
    logic           c_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
`ifdef BCD_SUB_EN
    logic           sub_r;
`endif
    logic [W-1:0]   sum_r;
    logic           cout_r;
    logic           busy_r;
    logic           done_r;
    logic           invalid_r;

    logic [3:0]     a_dig_s;
    logic [3:0]     b_dig_s;
    logic [3:0]     b_adj_s;
    logic [4:0]     res_s;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            bad = bad | (v[4*k +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Returns {decimal carry, result digit}; +6 skips the six unused codes.
    function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
        logic [4:0] z;
        logic [4:0] t;
        z = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        t = z + 5'd6;
        return (z > 5'd9) ? {1'b1, t[3:0]} : {1'b0, z[3:0]};
    endfunction

    // Current digit slice and its (optionally nine's-complemented) sum.
    always_comb begin
        a_dig_s = a_r[{idx_r, 2'b00} +: 4];
        b_dig_s = b_r[{idx_r, 2'b00} +: 4];
`ifdef BCD_SUB_EN
        if (sub_r) begin
            b_adj_s = 4'd9 - b_dig_s;
        end else begin
            b_adj_s = b_dig_s;
        end
`else
        b_adj_s = b_dig_s;
`endif
        res_s = digit_add(a_dig_s, b_adj_s, c_r);
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            c_r       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
`ifdef BCD_SUB_EN
            sub_r     <= 1'b0;
`endif
            sum_r     <= '0;
            cout_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
`ifdef BCD_SUB_EN
                        sub_r     <= bus.sub;
                        c_r       <= bus.sub ? 1'b1 : bus.cin;
`else
                        c_r       <= bus.cin;
`endif
                        sum_r     <= '0;
                        idx_r     <= '0;
                        invalid_r <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= res_s[3:0];
                    c_r <= res_s[4];
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= res_s[4];
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.invalid = invalid_r;
endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed-vector bench for bcd_adder_serial at DIGITS=4, plus DIGITS=1/16 sweeps.
// Subtract expectations depend on whether BCD_SUB_EN is defined.
module tb_bcd_adder_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_adder_serial_if #(.DIGITS(4))  if4 ();
    bcd_adder_serial_if #(.DIGITS(1))  if1 ();
    bcd_adder_serial_if #(.DIGITS(16)) if16 ();

    bcd_adder_serial #(.DIGITS(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    bcd_adder_serial #(.DIGITS(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
    bcd_adder_serial #(.DIGITS(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        inv;
    } vec_t;

    vec_t tbl [11];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int n, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic start);
        case (n)
            1: begin
                if1.a = a[3:0]; if1.b = b[3:0]; if1.cin = cin; if1.sub = sub; if1.start = start;
            end
            16: begin
                if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub; if16.start = start;
            end
            default: begin
                if4.a = a[15:0]; if4.b = b[15:0]; if4.cin = cin; if4.sub = sub; if4.start = start;
            end
        endcase
    endtask

    task automatic snap(input int n, output logic d, output logic bz, output logic co,
                        output logic inv, output logic [63:0] s);
        case (n)
            1: begin
                d = if1.done; bz = if1.busy; co = if1.cout; inv = if1.invalid; s = {60'd0, if1.sum};
            end
            16: begin
                d = if16.done; bz = if16.busy; co = if16.cout; inv = if16.invalid; s = if16.sum;
            end
            default: begin
                d = if4.done; bz = if4.busy; co = if4.cout; inv = if4.invalid; s = {48'd0, if4.sum};
            end
        endcase
    endtask

    function automatic longint unsigned bcd2int(input logic [63:0] v, input int n);
        longint unsigned r;
        r = 0;
        for (int k = n - 1; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] int2bcd(input longint unsigned x, input int n);
        logic [63:0] v;
        v = 64'd0;
        for (int k = 0; k < n; k++) begin
            v[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    // Decimal reference: plain integer arithmetic, modulo 10^n.
    task automatic ref_op(input int n, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          output logic [63:0] s, output logic co);
        longint unsigned av, bv, p, r;
        logic eff_sub;
`ifdef BCD_SUB_EN
        eff_sub = sub;
`else
        eff_sub = 1'b0;
`endif
        av = bcd2int(a, n);
        bv = bcd2int(b, n);
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        if (eff_sub) begin
            co = (av >= bv);
            r  = (av >= bv) ? (av - bv) : (p - (bv - av));
        end else begin
            r  = av + bv + longint'(cin);
            co = (r >= p);
            r  = r % p;
        end
        s = int2bcd(r, n);
    endtask

    // One start pulse; lat counts cycles from the start cycle to the done cycle.
    task automatic run_op(input int n, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          output logic [63:0] s, output logic co, output logic inv,
                          output int lat);
        logic d, bz, co2, inv2;
        logic [63:0] s2;
        @(negedge clk);
        set_in(n, a, b, cin, sub, 1'b1);
        @(negedge clk);
        set_in(n, a, b, cin, sub, 1'b0);
        lat = 1;
        snap(n, d, bz, co, inv, s);
        while (!d && lat < 60) begin
            @(negedge clk);
            lat++;
            snap(n, d, bz, co, inv, s);
        end
        n_vec++;
        @(negedge clk);
        snap(n, d, bz, co2, inv2, s2);
        chk("done_one_cycle", {63'd0, d}, 64'd0);
        chk("busy_after_done", {63'd0, bz}, 64'd0);
    endtask

    initial begin
        logic [63:0] s, es, ra, rb;
        logic co, inv, eco, d, bz, rcin, rsub;
        int lat, ndone, first_at, second_at;
        logic [63:0] dsum [2];

        tbl[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
        tbl[1]  = '{16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[3]  = '{16'h4321, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef BCD_SUB_EN
        tbl[4]  = '{16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0};
        tbl[5]  = '{16'h0123, 16'h0500, 1'b0, 1'b1, 16'h9623, 1'b0, 1'b0};
        tbl[6]  = '{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0};
        tbl[7]  = '{16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0};
        tbl[8]  = '{16'h0123, 16'h0123, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
`else
        tbl[4]  = '{16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0};
        tbl[5]  = '{16'h0123, 16'h0500, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0};
        tbl[6]  = '{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0624, 1'b0, 1'b0};
        tbl[7]  = '{16'h0123, 16'h0500, 1'b1, 1'b1, 16'h0624, 1'b0, 1'b0};
        tbl[8]  = '{16'h0123, 16'h0123, 1'b0, 1'b1, 16'h0246, 1'b0, 1'b0};
`endif
        tbl[9]  = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        set_in(4, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        set_in(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        set_in(16, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        foreach (ra[i]) ra[i] = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (n == 1 || n == 4 || n == 16) begin
                snap(n, d, bz, co, inv, s);
                chk("reset_outputs", {s[59:0], d, bz, co, inv}, 64'd0);
            end
        end
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(4, {48'd0, tbl[i].a}, {48'd0, tbl[i].b}, tbl[i].cin, tbl[i].sub, s, co, inv, lat);
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'd5);
            chk($sformatf("invalid[%0d]", i), {63'd0, inv}, {63'd0, tbl[i].inv});
            if (!tbl[i].inv) begin
                chk($sformatf("sum[%0d]", i), s, {48'd0, tbl[i].s});
                chk($sformatf("cout[%0d]", i), {63'd0, co}, {63'd0, tbl[i].co});
            end
        end

        // start held for 12 cycles: two ops, a disturbed mid-RUN then restored.
        ndone = 0; first_at = -1; second_at = -1;
        dsum[0] = 64'd0; dsum[1] = 64'd0;
        @(negedge clk);
        set_in(4, 64'h0001, 64'h0001, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            snap(4, d, bz, co, inv, s);
            if (d) begin
                if (ndone == 0) first_at = i;
                if (ndone == 1) second_at = i;
                if (ndone < 2) dsum[ndone] = s;
                ndone++;
            end
            if (i == 2) if4.a = 16'h0005;
            if (i == 4) if4.a = 16'h0001;
            if (i == 12) if4.start = 1'b0;
        end
        n_vec += 2;
        chk("overlap_done_count", 64'(ndone), 64'd2);
        chk("overlap_first_done", 64'(first_at), 64'd5);
        chk("overlap_spacing", 64'(second_at - first_at), 64'd6);
        chk("overlap_sum0", dsum[0], 64'h0002);
        chk("overlap_sum1", dsum[1], 64'h0002);

        // Leave cout=1 behind, then reset mid-RUN of the next operation.
        run_op(4, 64'h9999, 64'h0001, 1'b0, 1'b0, s, co, inv, lat);
        chk("pre_reset_cout", {63'd0, co}, 64'd1);
        @(negedge clk);
        set_in(4, 64'h1111, 64'h2222, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap(4, d, bz, co, inv, s);
        chk("rst_busy", {63'd0, bz}, 64'd0);
        chk("rst_done", {63'd0, d}, 64'd0);
        chk("rst_sum", s, 64'd0);
        chk("rst_cout", {63'd0, co}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            snap(4, d, bz, co, inv, s);
            if (d) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        n_vec++;

        // Random valid operands at both parameter extremes.
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 1 : 16;
            for (int v = 0; v < 8; v++) begin
                ra = 64'd0; rb = 64'd0;
                for (int k = 0; k < n; k++) begin
                    ra[4*k +: 4] = 4'($urandom_range(0, 9));
                    rb[4*k +: 4] = 4'($urandom_range(0, 9));
                end
                rcin = 1'($urandom_range(0, 1));
                rsub = 1'($urandom_range(0, 1));
                ref_op(n, ra, rb, rcin, rsub, es, eco);
                run_op(n, ra, rb, rcin, rsub, s, co, inv, lat);
                chk($sformatf("d%0d_latency", n), 64'(lat), 64'(n + 1));
                chk($sformatf("d%0d_sum", n), s, es);
                chk($sformatf("d%0d_cout", n), {63'd0, co}, {63'd0, eco});
                chk($sformatf("d%0d_invalid", n), {63'd0, inv}, 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_adder_serial.md
# bcd_adder_serial

Parametrised multi-digit packed-BCD adder/subtractor. It processes one decimal digit per clock, least-significant digit first, with a start/done handshake. It is the sequential, N-digit successor to the single-digit combinational BCD adder in the arithmetic library. It is intended for counters, display pipelines and decimal accumulators that need wide BCD operands without a long combinational carry chain.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per operand; legal range 1 to 16.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  4*DIGITS  packed-BCD operand A; digit k is a[4k+3:4k].
- b  input  4*DIGITS  packed-BCD operand B, same packing.
- cin  input  1  decimal carry-in; add mode only.
- sub  input  1  1 = compute A - B, 0 = compute A + B + cin.
- sum  output  4*DIGITS  packed-BCD result; held until the next accepted start.
- cout  output  1  decimal carry out; in subtract mode, 1 means no borrow.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- invalid  output  1  some accepted operand digit was greater than 9; held with the result.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The digit counter idx runs from 0 to DIGITS-1.
- IDLE:
  - When start=1, capture a, b, sub and cin into internal registers.
  - Clear sum, set idx=0, go to RUN.
  - Carry register c = sub ? 1 : cin.
  - invalid = 1 if any captured digit of a or b is greater than 9, else 0.
- RUN, each cycle, using a_d = captured A digit idx and b_d = captured B digit idx:
  - Compute b' = sub ? (9 - b_d) : b_d, where 9 - b_d is a 4-bit subtraction truncated to 4 bits.
  - Compute the 5-bit value z = a_d + b' + c.
  - If z > 9: sum digit idx = (z + 6)[3:0] and c = 1. Otherwise sum digit idx = z[3:0] and c = 0.
  - If idx = DIGITS-1: cout = new c, go to DONE. Otherwise idx = idx + 1.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy stays 1 in DONE.
- Operands with invalid digits still go through the same rule, and the result is deterministic. invalid is the only indication of bad input; the bench must not check sum when invalid=1.
- Subtract mode uses ten's-complement arithmetic:
  - If A >= B: sum = A - B, cout = 1.
  - If A < B: sum = 10^DIGITS - (B - A), cout = 0.
- start is ignored while busy=1 and is never queued. Changes to a, b, sub or cin after capture have no effect on the current operation.
- sum, cout and invalid hold their values in IDLE until the next accepted start. On that start, sum clears to 0.

## Timing
- Reset: rst=1 at a rising edge forces state=IDLE, idx=0, c=0, sum=0, cout=0, busy=0, done=0, invalid=0.
  - This takes priority over start and over any in-progress operation.
  - A reset mid-RUN discards the partial result.
- Latency: start is sampled high at edge E0. RUN covers edges E1 to E_DIGITS, and done is high in the cycle following edge E_DIGITS.
  - done is high DIGITS+1 cycles after the cycle in which start was asserted.
- Throughput: one operation per DIGITS+2 cycles.
  - The earliest next start is sampled in the cycle after done. start held high continuously gives back-to-back operations with this spacing.
- busy rises in the cycle after the accepted start and falls in the cycle after done.
- Partial sum digits update progressively during RUN. sum is defined only from done onward.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BCD_SUB_EN:
  - Defined: subtract mode is implemented as described.
  - Not defined: the sub port is still present but ignored (treated as 0). The captured sub register and the nine's-complement logic are removed, and the block is add-only.

## Test plan
All scenarios use DIGITS=4, except the last.
- Basic add: a=0x1234, b=0x5678, cin=0, start for 1 cycle -> done exactly 5 cycles later; sum=0x6912, cout=0, invalid=0.
- Carry ripple and cin: a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x0999, b=0x0001, cin=0 -> sum=0x1000, cout=0.
- Subtract (BCD_SUB_EN defined):
  - a=0x0500, b=0x0123, sub=1 -> sum=0x0377, cout=1.
  - a=0x0123, b=0x0500, sub=1 -> sum=0x9623, cout=0.
  - cin=1 must not change either result.
- Handshake and overlap: start held high for 12 cycles with a=0x0001, b=0x0001 -> exactly two done pulses, spaced 6 cycles apart, each with sum=0x0002. Changing a during RUN does not alter the result.
- Invalid and reset: a=0x00A0 -> invalid=1 at done. A new start with valid operands clears invalid to 0. A second operation with rst=1 asserted during RUN -> the next cycle shows busy=0, done=0, sum=0, cout=0, and no done pulse follows.
- Parameter sweep at DIGITS=1 and DIGITS=16: random valid operands checked against a decimal reference model -> done latency is DIGITS+1 cycles and every result matches.
